// File: rtl/bit_mask_splitter.sv
// Splits one mask word into one-hot beats, lowest set bit first, each beat tagged with
// its bit index and a last flag. An all-zero word produces a single empty beat.
module bit_mask_splitter #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDXW-1:0]  out_index,
  output logic             out_last,
  output logic             out_empty
);

  // state | meaning
  // IDLE  | waiting for a mask word, in_ready high
  // EMIT  | presenting the lowest remaining bit of pending, one beat per transfer

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] lowest;
  logic [WIDTH-1:0] remaining;
  logic [IDXW-1:0]  lowest_idx;
  logic             emit;

  assign emit      = (state == EMIT);
  assign lowest    = pending & (~pending + WIDTH'(1));
  assign remaining = pending & (pending - WIDTH'(1));

  always_comb begin
    lowest_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lowest[i]) lowest_idx = lowest_idx | IDXW'(i);
    end
  end

  // Beat fields are gated by EMIT so IDLE shows all-zero outputs.
  assign in_ready   = !emit;
  assign out_valid  = emit;
  assign out_onehot = emit ? lowest : '0;
  assign out_index  = emit ? lowest_idx : '0;
  assign out_last   = emit && (remaining == '0);
  assign out_empty  = emit && (pending == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pending <= in_word;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            pending <= remaining;
            if (remaining == '0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
